// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
package dmem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } arb_state_t;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   localparam int DEF_DATA_W    = 32;
   localparam int DEF_ADDR_W    = 32;
   localparam int DEF_MAX_BURST = 8;

   // Wide enough for the largest allowed burst length (255).
   localparam int BURST_CNT_W = 8;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way winner select: round-robin or fixed priority (m0 first).
module rr_arb2
   import dmem_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_owner,
   input  logic       rr_mode,
   output logic       grant
);

   // On contention, give the slot to whoever did not own last time (or m0 when fixed).
   always_comb begin
      grant = M0;
      if (req[0] && req[1]) begin
         grant = rr_mode ? ~last_owner : M0;
      end else if (req[1]) begin
         grant = M1;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a single-port data memory between a CPU port (m0) and a loader (m1),
// with optional locked bursts bounded by MAX_BURST.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int MAX_BURST = DEF_MAX_BURST,
   parameter int RR_MODE   = 1
)(
   input  logic              clk,
   input  logic              Reset,
   input  logic              m0_req,
   input  logic              m1_req,
   input  logic              m0_wr,
   input  logic              m1_wr,
   input  logic              m0_lock,
   input  logic              m1_lock,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m0_gnt,
   output logic              m1_gnt,
   output logic              m0_done,
   output logic              m1_done,
   output logic [DATA_W-1:0] m0_rdata,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] DAddr,
   output logic [DATA_W-1:0] DataIn,
   output logic              RD,
   output logic              WR,
   input  logic [DATA_W-1:0] DataOut
);

   localparam logic [BURST_CNT_W-1:0] BURST_LIMIT = BURST_CNT_W'(MAX_BURST);
   localparam logic                   RR_EN       = (RR_MODE != 0);

   arb_state_t              state;
   arb_state_t              next_state;
   logic                    owner;
   logic                    last_owner;
   logic                    winner;
   logic                    lat_wr;
   logic                    lat_lock;
   logic [ADDR_W-1:0]       lat_addr;
   logic [DATA_W-1:0]       lat_wdata;
   logic [BURST_CNT_W-1:0]  burst_cnt;

   logic                    any_req;
   logic                    owner_req;
   logic                    burst_go;
   logic                    load_src;
   logic                    src_wr;
   logic                    src_lock;
   logic [ADDR_W-1:0]       src_addr;
   logic [DATA_W-1:0]       src_wdata;

   assign any_req   = m0_req | m1_req;
   assign owner_req = (owner == M1) ? m1_req : m0_req;
   assign burst_go  = lat_lock & owner_req & (burst_cnt < BURST_LIMIT);

   // A new ownership loads from the winner; a burst continuation reloads from the owner.
   assign load_src  = (state == IDLE) ? winner : owner;
   assign src_wr    = load_src ? m1_wr    : m0_wr;
   assign src_lock  = load_src ? m1_lock  : m0_lock;
   assign src_addr  = load_src ? m1_addr  : m0_addr;
   assign src_wdata = load_src ? m1_wdata : m0_wdata;

   assign DAddr  = lat_addr;
   assign DataIn = lat_wdata;

   rr_arb2 u_arb (
      .req        ({m1_req, m0_req}),
      .last_owner (last_owner),
      .rr_mode    (RR_EN),
      .grant      (winner)
   );

   // State register; reset drops any in-flight access back to IDLE.
   always_ff @(posedge clk) begin
      if (!Reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Sequencing: IDLE samples requests, ISSUE lasts one cycle, RESP either bursts or releases.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    next_state = any_req ? ISSUE : IDLE;
         ISSUE:   next_state = RESP;
         RESP:    next_state = burst_go ? ISSUE : IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Request latching, ownership tracking, burst counting and read-data capture.
   always_ff @(posedge clk) begin
      if (!Reset) begin
         owner      <= M0;
         last_owner <= M1;
         lat_wr     <= 1'b0;
         lat_lock   <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         burst_cnt  <= '0;
         m0_rdata   <= '0;
         m1_rdata   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  owner      <= winner;
                  last_owner <= winner;
                  lat_wr     <= src_wr;
                  lat_lock   <= src_lock;
                  lat_addr   <= src_addr;
                  lat_wdata  <= src_wdata;
                  burst_cnt  <= BURST_CNT_W'(1);
               end
            end
            ISSUE: begin
               if (!lat_wr) begin
                  if (owner == M1) begin
                     m1_rdata <= DataOut;
                  end else begin
                     m0_rdata <= DataOut;
                  end
               end
            end
            RESP: begin
               if (burst_go) begin
                  lat_wr    <= src_wr;
                  lat_lock  <= src_lock;
                  lat_addr  <= src_addr;
                  lat_wdata <= src_wdata;
                  burst_cnt <= burst_cnt + 1'b1;
               end else begin
                  burst_cnt <= '0;
               end
            end
            default: begin
               burst_cnt <= '0;
            end
         endcase
      end
   end

   // Strobes: memory command and grant during ISSUE, owner's done during RESP.
   always_comb begin
      RD      = 1'b0;
      WR      = 1'b0;
      m0_gnt  = 1'b0;
      m1_gnt  = 1'b0;
      m0_done = 1'b0;
      m1_done = 1'b0;
      if (state == ISSUE) begin
         RD     = ~lat_wr;
         WR     = lat_wr;
         m0_gnt = (owner == M0);
         m1_gnt = (owner == M1);
      end else if (state == RESP) begin
         m0_done = (owner == M0);
         m1_done = (owner == M1);
      end
   end

endmodule
